// File: rtl/mmu_pkg.sv
// Shared types and field helpers for the two-level page-table walker.
// Holds the walker state enum, entry/field positions and extractors.
package mmu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      PDE_REQ,
      PDE_DATA,
      PTE_REQ,
      PTE_DATA,
      RESP
   } state_e;

   localparam int PRESENT_BIT = 0;
   localparam int DIR_MSB     = 31;
   localparam int DIR_LSB     = 22;
   localparam int TBL_MSB     = 21;
   localparam int TBL_LSB     = 12;
   localparam int OFF_W       = 12;

   function automatic logic [9:0] get_dir(input logic [31:0] a);
      return a[DIR_MSB:DIR_LSB];
   endfunction

   function automatic logic [9:0] get_tbl(input logic [31:0] a);
      return a[TBL_MSB:TBL_LSB];
   endfunction

   function automatic logic [19:0] get_frame(input logic [31:0] a);
      return a[31:OFF_W];
   endfunction

endpackage

// File: rtl/page_tlb.sv
// Fully associative translation cache: combinational hit/frame lookup,
// fill into first invalid entry else round-robin victim, global flush.
// Ports: lookup_tag -> hit/hit_frame; fill_en/fill_tag/fill_frame; flush.
module page_tlb #(
   parameter int ENTRIES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [19:0] lookup_tag,
   output logic        hit,
   output logic [19:0] hit_frame,
   input  logic        fill_en,
   input  logic [19:0] fill_tag,
   input  logic [19:0] fill_frame,
   input  logic        flush
);
   import mmu_pkg::*;

   localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [19:0]        tag_q   [ENTRIES];
   logic [19:0]        tag_d   [ENTRIES];
   logic [19:0]        frame_q [ENTRIES];
   logic [19:0]        frame_d [ENTRIES];
   logic [IDX_W-1:0]   rr_q, rr_d;
   logic [IDX_W-1:0]   victim;
   logic               found_free;

   always_comb begin
      hit       = 1'b0;
      hit_frame = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && tag_q[i] == lookup_tag) begin
            hit       = 1'b1;
            hit_frame = frame_q[i];
         end
      end
   end

   always_comb begin
      valid_d    = valid_q;
      tag_d      = tag_q;
      frame_d    = frame_q;
      rr_d       = rr_q;
      victim     = rr_q;
      found_free = 1'b0;
      // Scan downward so the lowest-numbered free slot wins.
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            victim     = IDX_W'(i);
            found_free = 1'b1;
         end
      end
      if (fill_en) begin
         valid_d[victim] = 1'b1;
         tag_d[victim]   = fill_tag;
         frame_d[victim] = fill_frame;
         if (!found_free) begin
            rr_d = (rr_q == IDX_W'(ENTRIES - 1)) ? '0 : rr_q + IDX_W'(1);
         end
      end
      // Flush overrides any same-cycle fill.
      if (flush) begin
         valid_d = '0;
         rr_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         rr_q    <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]   <= '0;
            frame_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         rr_q    <= rr_d;
         tag_q   <= tag_d;
         frame_q <= frame_d;
      end
   end

endmodule

// File: rtl/page_walker.sv
// Two-level page-table walker with translation cache in front of a ram
// read port. Ports: req_* in, resp_* out, tlb_flush, mem_* to ram.
module page_walker #(
   parameter logic [31:0] PD_BASE     = 32'h0,
   parameter int          TLB_ENTRIES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_vaddr,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_paddr,
   output logic        resp_fault,
   output logic        resp_lvl,
   input  logic        tlb_flush,
   output logic [29:0] mem_addr,
   output logic        mem_read_en,
   input  logic [31:0] mem_rdata
);
   import mmu_pkg::*;

   state_e      state_q, state_d;
   logic [31:0] vaddr_q, vaddr_d;
   logic [19:0] pde_q, pde_d;
   logic [31:0] paddr_q, paddr_d;
   logic        fault_q, fault_d;
   logic        lvl_q, lvl_d;
   logic        tlb_hit;
   logic [19:0] tlb_frame;
   logic        fill_en;
   logic        unused_rdata;

   assign unused_rdata = ^mem_rdata[11:1];

   page_tlb #(.ENTRIES(TLB_ENTRIES)) u_tlb (
      .clk        (clk),
      .rst_n      (rst_n),
      .lookup_tag (get_frame(vaddr_q)),
      .hit        (tlb_hit),
      .hit_frame  (tlb_frame),
      .fill_en    (fill_en),
      .fill_tag   (get_frame(vaddr_q)),
      .fill_frame (get_frame(mem_rdata)),
      .flush      (tlb_flush)
   );

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_paddr = paddr_q;
   assign resp_fault = fault_q;
   assign resp_lvl   = lvl_q;

   always_comb begin
      mem_read_en = 1'b0;
      mem_addr    = '0;
      if (state_q == PDE_REQ) begin
         mem_read_en = 1'b1;
         mem_addr    = {PD_BASE[31:12], get_dir(vaddr_q)};
      end else if (state_q == PTE_REQ) begin
         mem_read_en = 1'b1;
         mem_addr    = {pde_q, get_tbl(vaddr_q)};
      end
   end

   always_comb begin
      state_d = state_q;
      vaddr_d = vaddr_q;
      pde_d   = pde_q;
      paddr_d = paddr_q;
      fault_d = fault_q;
      lvl_d   = lvl_q;
      fill_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               vaddr_d = req_vaddr;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            // A same-cycle flush forces a walk even on a hit.
            if (tlb_hit && !tlb_flush) begin
               paddr_d = {tlb_frame, vaddr_q[OFF_W-1:0]};
               fault_d = 1'b0;
               lvl_d   = 1'b0;
               state_d = RESP;
            end else begin
               state_d = PDE_REQ;
            end
         end
         PDE_REQ: state_d = PDE_DATA;
         PDE_DATA: begin
            pde_d = get_frame(mem_rdata);
            if (!mem_rdata[PRESENT_BIT]) begin
               paddr_d = '0;
               fault_d = 1'b1;
               lvl_d   = 1'b0;
               state_d = RESP;
            end else begin
               state_d = PTE_REQ;
            end
         end
         PTE_REQ: state_d = PTE_DATA;
         PTE_DATA: begin
            if (!mem_rdata[PRESENT_BIT]) begin
               paddr_d = '0;
               fault_d = 1'b1;
               lvl_d   = 1'b1;
            end else begin
               paddr_d = {get_frame(mem_rdata), vaddr_q[OFF_W-1:0]};
               fault_d = 1'b0;
               lvl_d   = 1'b0;
               fill_en = 1'b1;
            end
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vaddr_q <= '0;
         pde_q   <= '0;
         paddr_q <= '0;
         fault_q <= 1'b0;
         lvl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         vaddr_q <= vaddr_d;
         pde_q   <= pde_d;
         paddr_q <= paddr_d;
         fault_q <= fault_d;
         lvl_q   <= lvl_d;
      end
   end

endmodule
